// File: rtl/fxp_pkg.sv
// Shared Q4.11 fixed-point definitions for the vec_dot lanes and other PEs.
package fxp_pkg;
  localparam int WIDTH = 16;
  localparam int FRAC  = 11;

  typedef logic signed [15:0] fxp_t;

  localparam fxp_t FXP_MAX = 16'h7FFF;
  localparam fxp_t FXP_MIN = 16'h8000;
  localparam fxp_t FXP_ONE = 16'h0800;
endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full product, round half up, saturate.
// Zero latency; no flow control.
module fxp_mul_sat #(
  parameter int WIDTH = fxp_pkg::WIDTH,
  parameter int FRAC  = fxp_pkg::FRAC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);
  import fxp_pkg::*;

  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] HI  = PW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] LO  = ~HI;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // One guard bit above the 2*WIDTH product keeps the rounding add from wrapping.
  assign a_ext   = {{(WIDTH + 1){a[WIDTH-1]}}, a};
  assign b_ext   = {{(WIDTH + 1){b[WIDTH-1]}}, b};
  assign prod    = a_ext * b_ext;
  assign shifted = (prod + RND) >>> FRAC;

  always_comb begin
    res = shifted[WIDTH-1:0];
    if (shifted > HI) begin
      res = HI[WIDTH-1:0];
    end else if (shifted < LO) begin
      res = LO[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/vec_dot_basic_cell.sv
// Scalar vec_dot lane: capture operands, then register the saturated Q4.11 product.
// Latency 2 edges from en; finish is sticky until en drops, which also aborts.
module vec_dot_basic_cell #(
  parameter int WIDTH = fxp_pkg::WIDTH,
  parameter int FRAC  = fxp_pkg::FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  output logic [WIDTH-1:0] dot_out,
  output logic             finish
);
  import fxp_pkg::*;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             s1_valid;
  logic [WIDTH-1:0] prod;

  fxp_mul_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a   (a_q),
    .b   (b_q),
    .res (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s1_valid <= 1'b0;
      dot_out  <= '0;
      finish   <= 1'b0;
    end else if (!en) begin
      s1_valid <= 1'b0;
      finish   <= 1'b0;
    end else if (!finish) begin
      // Operands keep refreshing until finish; the last capture before it wins.
      a_q      <= vec_a;
      b_q      <= vec_b;
      s1_valid <= 1'b1;
      if (s1_valid) begin
        dot_out <= prod;
        finish  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vec_dot_basic_cell.sv
// Directed plus random checks of the Q4.11 lane with an expected-result queue.
module tb_vec_dot_basic_cell;
  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] vec_a;
  logic [15:0] vec_b;
  logic [15:0] dot_out;
  logic        finish;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  vec_dot_basic_cell dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .vec_a   (vec_a),
    .vec_b   (vec_b),
    .dot_out (dot_out),
    .finish  (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    p = (p + 1024) >>> 11;
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation: start, result after two edges, hold with changed inputs, then drop en.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    logic [15:0] want;
    exp_q.push_back(exp);
    vec_a = a;
    vec_b = b;
    en    = 1'b1;
    @(negedge clk);
    chk({tag, "_fin_early"}, {15'd0, finish}, 16'd0);
    @(negedge clk);
    chk({tag, "_fin"}, {15'd0, finish}, 16'd1);
    if (finish === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
        want = exp_q.pop_front();
        chk({tag, "_dot"}, dot_out, want);
        vec_a = 16'h1000;
        vec_b = 16'h1000;
        @(negedge clk);
        chk({tag, "_hold_dot"}, dot_out, want);
        chk({tag, "_hold_fin"}, {15'd0, finish}, 16'd1);
      end
    end else begin
      void'(exp_q.pop_front());
    end
    en = 1'b0;
    @(negedge clk);
    chk({tag, "_off_fin"}, {15'd0, finish}, 16'd0);
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] ra;
    logic [15:0] rb;
    rst   = 1'b0;
    en    = 1'b0;
    vec_a = '0;
    vec_b = '0;
    #12;
    chk("rst_dot", dot_out, 16'h0000);
    chk("rst_fin", {15'd0, finish}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("ident", 16'h0800, 16'h0800, 16'h0800);
    run_op("sign", 16'h1000, 16'hF400, 16'hE800);
    run_op("sat_pp", 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_op("sat_nn", 16'h8000, 16'h8000, 16'h7FFF);
    run_op("sat_np", 16'h8000, 16'h7FFF, 16'h8000);
    run_op("rnd_p", 16'h0001, 16'h0400, 16'h0001);
    run_op("rnd_n", 16'h0001, 16'hFC00, 16'h0000);
    run_op("rnd_3", 16'h0003, 16'h0400, 16'h0002);

    // Abort after a single enabled cycle.
    prev  = dot_out;
    vec_a = 16'h0123;
    vec_b = 16'h0456;
    en    = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("abort_fin", {15'd0, finish}, 16'd0);
    chk("abort_dot", dot_out, prev);
    @(negedge clk);
    chk("abort_fin2", {15'd0, finish}, 16'd0);
    run_op("restart", 16'h0C00, 16'h0C00, 16'h1200);

    // Async reset between edges, mid-operation.
    vec_a = 16'h0800;
    vec_b = 16'h0C00;
    en    = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_dot", dot_out, 16'h0000);
    chk("arst_fin", {15'd0, finish}, 16'd0);
    @(negedge clk);
    chk("arst_hold_fin", {15'd0, finish}, 16'd0);
    rst = 1'b1;
    run_op("post_rst", 16'h0800, 16'h0C00, 16'h0C00);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 16'hFFFF));
      if (i < 4) begin
        ra = {{4{ra[11]}}, ra[11:0]};
      end
      run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
    end

    if (exp_q.size() != 0) begin
      chk("sb_leftover", 16'(exp_q.size()), 16'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
